// File: rtl/mac_axil_reg_slave.sv
// AXI4-Lite responder for the MAC register space: one outstanding transaction,
// address decode against a base window, single-cycle strobes onto the register bus.
module mac_axil_reg_slave #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic              Clk_reg,
    input  logic              ResetB,
    input  logic [31:0]       S_AXI_awaddr,
    input  logic              S_AXI_awvalid,
    output logic              S_AXI_awready,
    input  logic [31:0]       S_AXI_wdata,
    input  logic              S_AXI_wvalid,
    output logic              S_AXI_wready,
    output logic [1:0]        S_AXI_bresp,
    output logic              S_AXI_bvalid,
    input  logic              S_AXI_bready,
    input  logic [31:0]       S_AXI_araddr,
    input  logic              S_AXI_arvalid,
    output logic              S_AXI_arready,
    output logic [31:0]       S_AXI_rdata,
    output logic [1:0]        S_AXI_rresp,
    output logic              S_AXI_rvalid,
    input  logic              S_AXI_rready,
    output logic [ADDR_W-1:0] Reg_addr,
    output logic [31:0]       Reg_wdata,
    output logic              Reg_wr,
    output logic              Reg_rd,
    input  logic [31:0]       Reg_rdata,
    input  logic              Reg_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP
    } state_t;

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic                r_live;
    logic                r_aw_held;
    logic                r_w_held;
    logic                r_wr_hit;
    logic                r_rd_prio;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;
    logic [TW-1:0]       r_timer;

    logic w_idle;
    logic w_rd_win;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_ar_fire;
    logic w_wr_go;
    logic w_wr_hit_now;
    logic w_aw_hit;
    logic w_ar_hit;
    logic w_tmo;
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^{S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};

    // r_live keeps every ready low while reset is held, without routing reset into logic.
    assign w_idle   = (r_state == S_IDLE) && r_live;
    assign w_rd_win = r_rd_prio && S_AXI_arvalid && !r_aw_held && !r_w_held;
    assign w_aw_hit = (S_AXI_awaddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_ar_hit = (S_AXI_araddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_tmo    = (r_timer == TMAX);

    assign S_AXI_bvalid = (r_state == S_WR_RESP);
    assign S_AXI_rvalid = (r_state == S_RD_RESP);
    assign S_AXI_bresp  = r_bresp;
    assign S_AXI_rresp  = r_rresp;
    assign S_AXI_rdata  = r_rdata;
    assign Reg_addr     = r_addr;
    assign Reg_wdata    = r_wdata;
    assign Reg_wr       = (r_state == S_WR_REQ) && (r_timer == '0);
    assign Reg_rd       = (r_state == S_RD_REQ) && (r_timer == '0);

    always_ff @(posedge Clk_reg or negedge ResetB) begin
        if (!ResetB) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        S_AXI_awready = 1'b0;
        S_AXI_wready  = 1'b0;
        S_AXI_arready = 1'b0;
        w_next        = r_state;
        if (w_idle) begin
            S_AXI_awready = !r_aw_held && !w_rd_win;
            S_AXI_wready  = !r_w_held && !w_rd_win;
            S_AXI_arready = !r_aw_held && !r_w_held &&
                            (!(S_AXI_awvalid || S_AXI_wvalid) || r_rd_prio);
        end
        w_aw_fire    = S_AXI_awvalid && S_AXI_awready;
        w_w_fire     = S_AXI_wvalid && S_AXI_wready;
        w_ar_fire    = S_AXI_arvalid && S_AXI_arready;
        w_wr_go      = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
        w_wr_hit_now = w_aw_fire ? w_aw_hit : r_wr_hit;

        unique case (r_state)
            S_IDLE: begin
                if (w_idle && w_wr_go) begin
                    w_next = w_wr_hit_now ? S_WR_REQ : S_WR_RESP;
                end else if (w_ar_fire) begin
                    w_next = w_ar_hit ? S_RD_REQ : S_RD_RESP;
                end
            end
            S_WR_REQ:  if (Reg_ack || w_tmo) w_next = S_WR_RESP;
            S_WR_RESP: if (S_AXI_bready)     w_next = S_IDLE;
            S_RD_REQ:  if (Reg_ack || w_tmo) w_next = S_RD_RESP;
            S_RD_RESP: if (S_AXI_rready)     w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge Clk_reg or negedge ResetB) begin
        if (!ResetB) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_hit  <= 1'b0;
            r_rd_prio <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_timer   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_wr_hit  <= w_aw_hit;
                r_addr    <= S_AXI_awaddr[ADDR_W+1:2];
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_wdata;
            end
            if (w_ar_fire) begin
                r_addr <= S_AXI_araddr[ADDR_W+1:2];
            end

            // Timer is zero on the first request cycle, which is also the strobe cycle.
            if (r_state == S_WR_REQ || r_state == S_RD_REQ) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_idle && w_wr_go && !w_wr_hit_now) begin
                        r_bresp <= RESP_DECERR;
                    end else if (w_ar_fire && !w_ar_hit) begin
                        r_rresp <= RESP_DECERR;
                        r_rdata <= '0;
                    end
                end
                S_WR_REQ: begin
                    if (Reg_ack)    r_bresp <= RESP_OKAY;
                    else if (w_tmo) r_bresp <= RESP_SLVERR;
                end
                S_RD_REQ: begin
                    if (Reg_ack) begin
                        r_rresp <= RESP_OKAY;
                        r_rdata <= Reg_rdata;
                    end else if (w_tmo) begin
                        r_rresp <= RESP_SLVERR;
                        r_rdata <= '0;
                    end
                end
                // Finishing a write hands contention priority to reads and vice versa.
                S_WR_RESP: begin
                    if (S_AXI_bready) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_rd_prio <= 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (S_AXI_rready) begin
                        r_rd_prio <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_axil_reg_slave.sv
// Directed bench for mac_axil_reg_slave: write/read paths, decode error, timeout,
// arbitration alternation and reset during an open response.
module tb_mac_axil_reg_slave;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              Clk_reg = 1'b0;
    logic              ResetB  = 1'b0;
    logic [31:0]       S_AXI_awaddr;
    logic              S_AXI_awvalid;
    logic              S_AXI_awready;
    logic [31:0]       S_AXI_wdata;
    logic              S_AXI_wvalid;
    logic              S_AXI_wready;
    logic [1:0]        S_AXI_bresp;
    logic              S_AXI_bvalid;
    logic              S_AXI_bready;
    logic [31:0]       S_AXI_araddr;
    logic              S_AXI_arvalid;
    logic              S_AXI_arready;
    logic [31:0]       S_AXI_rdata;
    logic [1:0]        S_AXI_rresp;
    logic              S_AXI_rvalid;
    logic              S_AXI_rready;
    logic [ADDR_W-1:0] Reg_addr;
    logic [31:0]       Reg_wdata;
    logic              Reg_wr;
    logic              Reg_rd;
    logic [31:0]       Reg_rdata;
    logic              Reg_ack;

    logic ack_auto;
    logic ack_manual;
    int   n_checks  = 0;
    int   n_errs    = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   grants[$];

    mac_axil_reg_slave #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(32'h0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clk_reg      (Clk_reg),
        .ResetB       (ResetB),
        .S_AXI_awaddr (S_AXI_awaddr),
        .S_AXI_awvalid(S_AXI_awvalid),
        .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata  (S_AXI_wdata),
        .S_AXI_wvalid (S_AXI_wvalid),
        .S_AXI_wready (S_AXI_wready),
        .S_AXI_bresp  (S_AXI_bresp),
        .S_AXI_bvalid (S_AXI_bvalid),
        .S_AXI_bready (S_AXI_bready),
        .S_AXI_araddr (S_AXI_araddr),
        .S_AXI_arvalid(S_AXI_arvalid),
        .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata  (S_AXI_rdata),
        .S_AXI_rresp  (S_AXI_rresp),
        .S_AXI_rvalid (S_AXI_rvalid),
        .S_AXI_rready (S_AXI_rready),
        .Reg_addr     (Reg_addr),
        .Reg_wdata    (Reg_wdata),
        .Reg_wr       (Reg_wr),
        .Reg_rd       (Reg_rd),
        .Reg_rdata    (Reg_rdata),
        .Reg_ack      (Reg_ack)
    );

    always #5 Clk_reg = ~Clk_reg;

    // Register-file stand-in: either acks in the strobe cycle or follows ack_manual.
    assign Reg_ack = ack_auto ? (Reg_wr | Reg_rd) : ack_manual;

    // Strobe monitor: 1 = write grant, 2 = read grant.
    always @(posedge Clk_reg) begin
        if (Reg_wr) begin
            wr_pulses++;
            grants.push_back(1);
        end
        if (Reg_rd) begin
            rd_pulses++;
            grants.push_back(2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge Clk_reg);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int base;
        int g;

        S_AXI_awaddr  = '0;
        S_AXI_awvalid = 1'b0;
        S_AXI_wdata   = '0;
        S_AXI_wvalid  = 1'b0;
        S_AXI_bready  = 1'b0;
        S_AXI_araddr  = '0;
        S_AXI_arvalid = 1'b0;
        S_AXI_rready  = 1'b0;
        Reg_rdata     = '0;
        ack_auto      = 1'b1;
        ack_manual    = 1'b0;

        // Reset state: every output low.
        #1;
        check("rst_awready", 32'(S_AXI_awready), 32'h0);
        check("rst_wready",  32'(S_AXI_wready),  32'h0);
        check("rst_arready", 32'(S_AXI_arready), 32'h0);
        check("rst_bvalid",  32'(S_AXI_bvalid),  32'h0);
        check("rst_rvalid",  32'(S_AXI_rvalid),  32'h0);
        check("rst_reg_wr",  32'(Reg_wr),        32'h0);
        check("rst_reg_rd",  32'(Reg_rd),        32'h0);
        check("rst_reg_addr", 32'(Reg_addr),     32'h0);
        check("rst_rdata",   S_AXI_rdata,        32'h0);
        cyc();
        cyc();
        ResetB = 1'b1;
        cyc();
        cyc();

        // 1) AW+W together, immediate ack.
        S_AXI_awaddr  = 32'h10;
        S_AXI_awvalid = 1'b1;
        S_AXI_wdata   = 32'hA5A5_0001;
        S_AXI_wvalid  = 1'b1;
        #1;
        check("t1_awready", 32'(S_AXI_awready), 32'h1);
        check("t1_wready",  32'(S_AXI_wready),  32'h1);
        base = wr_pulses;
        cyc();
        S_AXI_awvalid = 1'b0;
        S_AXI_wvalid  = 1'b0;
        #1;
        check("t1_reg_wr",     32'(Reg_wr),       32'h1);
        check("t1_reg_addr",   32'(Reg_addr),     32'h4);
        check("t1_reg_wdata",  Reg_wdata,         32'hA5A5_0001);
        check("t1_bvalid_n1",  32'(S_AXI_bvalid), 32'h0);
        check("t1_awready_busy", 32'(S_AXI_awready), 32'h0);
        cyc();
        check("t1_bvalid_n2",  32'(S_AXI_bvalid), 32'h1);
        check("t1_bresp",      32'(S_AXI_bresp),  32'h0);
        check("t1_reg_wr_off", 32'(Reg_wr),       32'h0);
        check("t1_wr_pulses",  wr_pulses - base,  32'h1);
        S_AXI_bready = 1'b1;
        cyc();
        S_AXI_bready = 1'b0;
        check("t1_bvalid_clr", 32'(S_AXI_bvalid), 32'h0);

        // 2) W three cycles ahead of AW.
        S_AXI_wdata  = 32'h0000_BEEF;
        S_AXI_wvalid = 1'b1;
        #1;
        check("t2_wready", 32'(S_AXI_wready), 32'h1);
        base = wr_pulses;
        cyc();
        S_AXI_wvalid = 1'b0;
        #1;
        check("t2_wready_drop", 32'(S_AXI_wready),  32'h0);
        check("t2_arready_blk", 32'(S_AXI_arready), 32'h0);
        cyc();
        cyc();
        check("t2_no_early_wr", wr_pulses - base, 32'h0);
        S_AXI_awaddr  = 32'h20;
        S_AXI_awvalid = 1'b1;
        #1;
        check("t2_awready", 32'(S_AXI_awready), 32'h1);
        cyc();
        S_AXI_awvalid = 1'b0;
        #1;
        check("t2_reg_wr",    32'(Reg_wr),   32'h1);
        check("t2_reg_addr",  32'(Reg_addr), 32'h8);
        check("t2_reg_wdata", Reg_wdata,     32'h0000_BEEF);
        cyc();
        check("t2_bvalid", 32'(S_AXI_bvalid), 32'h1);
        check("t2_bresp",  32'(S_AXI_bresp),  32'h0);
        S_AXI_bready = 1'b1;
        cyc();
        S_AXI_bready = 1'b0;
        check("t2_single_wr", wr_pulses - base, 32'h1);

        // 3) Read 0x08, ack three cycles after the strobe, rready withheld.
        ack_auto      = 1'b0;
        ack_manual    = 1'b0;
        Reg_rdata     = 32'h1234_5678;
        S_AXI_araddr  = 32'h08;
        S_AXI_arvalid = 1'b1;
        #1;
        check("t3_arready", 32'(S_AXI_arready), 32'h1);
        base = rd_pulses;
        cyc();
        S_AXI_arvalid = 1'b0;
        #1;
        check("t3_reg_rd",   32'(Reg_rd),   32'h1);
        check("t3_reg_addr", 32'(Reg_addr), 32'h2);
        cyc();
        check("t3_reg_rd_once", 32'(Reg_rd), 32'h0);
        cyc();
        cyc();
        ack_manual = 1'b1;
        #1;
        check("t3_rvalid_wait", 32'(S_AXI_rvalid), 32'h0);
        cyc();
        ack_manual = 1'b0;
        Reg_rdata  = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t3_rvalid_hold", 32'(S_AXI_rvalid), 32'h1);
            check("t3_rdata",       S_AXI_rdata,       32'h1234_5678);
            check("t3_rresp",       32'(S_AXI_rresp),  32'h0);
            cyc();
        end
        S_AXI_rready = 1'b1;
        cyc();
        S_AXI_rready = 1'b0;
        check("t3_rvalid_clr", 32'(S_AXI_rvalid), 32'h0);
        check("t3_rd_pulses",  rd_pulses - base,  32'h1);

        // 4) Read outside the base window: DECERR, no strobe.
        base          = rd_pulses;
        S_AXI_araddr  = 32'h400;
        S_AXI_arvalid = 1'b1;
        cyc();
        S_AXI_arvalid = 1'b0;
        #1;
        check("t4_rvalid",  32'(S_AXI_rvalid), 32'h1);
        check("t4_rresp",   32'(S_AXI_rresp),  32'h3);
        check("t4_rdata",   S_AXI_rdata,       32'h0);
        check("t4_no_rd",   32'(Reg_rd),       32'h0);
        S_AXI_rready = 1'b1;
        cyc();
        S_AXI_rready = 1'b0;
        check("t4_rvalid_clr", 32'(S_AXI_rvalid), 32'h0);
        check("t4_rd_pulses",  rd_pulses - base,  32'h0);

        // 5) Write with no ack: SLVERR exactly TIMEOUT cycles after the strobe.
        S_AXI_awaddr  = 32'h0C;
        S_AXI_awvalid = 1'b1;
        S_AXI_wdata   = 32'hCAFE_0005;
        S_AXI_wvalid  = 1'b1;
        cyc();
        S_AXI_awvalid = 1'b0;
        S_AXI_wvalid  = 1'b0;
        #1;
        check("t5_reg_wr", 32'(Reg_wr), 32'h1);
        k = 0;
        while (!S_AXI_bvalid && k < 40) begin
            cyc();
            k++;
        end
        check("t5_latency", k,                    32'd16);
        check("t5_bresp",   32'(S_AXI_bresp),     32'h2);
        S_AXI_bready = 1'b1;
        cyc();
        S_AXI_bready = 1'b0;
        check("t5_bvalid_clr", 32'(S_AXI_bvalid), 32'h0);

        // Fresh reset so arbitration starts with writes favoured.
        ResetB = 1'b0;
        #1;
        check("rst2_awready",  32'(S_AXI_awready), 32'h0);
        check("rst2_reg_addr", 32'(Reg_addr),      32'h0);
        cyc();
        ResetB = 1'b1;
        cyc();
        cyc();

        // 6) AR, AW and W all valid continuously: grants alternate W,R,W,R.
        ack_auto = 1'b1;
        grants.delete();
        S_AXI_awaddr  = 32'h30;
        S_AXI_wdata   = 32'h0000_0066;
        S_AXI_araddr  = 32'h34;
        S_AXI_awvalid = 1'b1;
        S_AXI_wvalid  = 1'b1;
        S_AXI_arvalid = 1'b1;
        S_AXI_bready  = 1'b1;
        S_AXI_rready  = 1'b1;
        k = 0;
        while (grants.size() < 4 && k < 60) begin
            cyc();
            k++;
        end
        S_AXI_bready = 1'b0;
        check("t6_grant_count", grants.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            g = (i < grants.size()) ? grants[i] : 0;
            check($sformatf("t6_grant%0d", i), g, (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Next write reaches WR_RESP and stalls; reset must drop bvalid at once.
        k = 0;
        while (!S_AXI_bvalid && k < 20) begin
            cyc();
            k++;
        end
        check("t6_bvalid_open", 32'(S_AXI_bvalid), 32'h1);
        ResetB        = 1'b0;
        S_AXI_awvalid = 1'b0;
        S_AXI_wvalid  = 1'b0;
        S_AXI_arvalid = 1'b0;
        S_AXI_rready  = 1'b0;
        S_AXI_bready  = 1'b1;
        #1;
        check("t6_bvalid_async", 32'(S_AXI_bvalid), 32'h0);
        cyc();
        ResetB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t6_no_bresp", 32'(S_AXI_bvalid), 32'h0);
            check("t6_no_rresp", 32'(S_AXI_rvalid), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
